// File: rtl/im_fetch_master.sv
// Instruction-fetch responder: turns each IF fetch into one single-beat AXI4 read.
// Latency: 3 cycles minimum from request to delivery. Holds the IF stage in stall while AR or R is backpressured.
module im_fetch_master #(
  parameter int                  ID_WIDTH  = 4,
  parameter logic [ID_WIDTH-1:0] AR_ID     = '0,
  parameter logic [31:0]         NOP_INSTR = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_read,
  input  logic [31:0]         cpu_addr,
  input  logic                cpu_hold,
  output logic [31:0]         cpu_instr,
  output logic                if_stall,
  output logic                fetch_err,
  output logic [ID_WIDTH-1:0] ARID,
  output logic [31:0]         ARADDR,
  output logic [3:0]          ARLEN,
  output logic [2:0]          ARSIZE,
  output logic [1:0]          ARBURST,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [ID_WIDTH-1:0] RID,
  input  logic [31:0]         RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RLAST,
  input  logic                RVALID,
  output logic                RREADY
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic        addr_match;
  logic        rid_unused;

  assign rid_unused = ^RID;
  assign addr_match = cpu_read && (cpu_addr == addr_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_read) begin
          addr_d  = cpu_addr;
          state_d = S_AR;
        end
      end
      S_AR: begin
        if (ARREADY) state_d = S_R;
      end
      S_R: begin
        // A beat without RLAST is a protocol violation and is dropped.
        if (RVALID && RLAST) begin
          data_d  = (RRESP != 2'b00) ? NOP_INSTR : RDATA;
          err_d   = (RRESP != 2'b00);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (addr_match) begin
          err_d = 1'b0;
          if (!cpu_hold) state_d = S_IDLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ARID      = AR_ID;
    ARLEN     = 4'd0;
    ARSIZE    = 3'b010;
    ARBURST   = 2'b01;
    ARADDR    = addr_q;
    ARVALID   = (state_q == S_AR);
    RREADY    = (state_q == S_R);
    cpu_instr = '0;
    if_stall  = 1'b1;
    fetch_err = 1'b0;
    case (state_q)
      S_IDLE: if_stall = cpu_read;
      S_DONE: begin
        // A response for an address IF has moved away from is never shown.
        cpu_instr = data_q;
        if_stall  = !addr_match;
        fetch_err = addr_match && err_q;
      end
      default: if_stall = 1'b1;
    endcase
  end

endmodule

// File: doc/im_fetch_master.md
Name: im_fetch_master

Overview:
Responder side of the CPU instruction-fetch interface. It accepts fetch requests (read enable plus address) from the IF stage and converts each one into a single-beat AXI4 read on the instruction-memory port. It returns the instruction word to IF and drives the IF stall signal until a response that matches the current fetch address is available. It sits inside the CPU wrapper, between the IF stage and the AXI interconnect, and drives only the read channels (AR/R).

Parameters:
ID_WIDTH, 4, width of ARID/RID.
AR_ID, 0, constant ARID value driven on every request.
NOP_INSTR, 32'h0000_0013, instruction returned on error responses.

Ports:
clk  input  1  clock
rst  input  1  reset
cpu_read  input  1  IF fetch enable; low during WFI and reset
cpu_addr  input  32  IF fetch address; may change at any cycle (jump/branch redirect)
cpu_hold  input  1  pipeline frozen (MEM stall or hazard); IF will not consume the instruction this cycle
cpu_instr  output  32  fetched instruction, valid when if_stall=0 and cpu_read=1
if_stall  output  1  IF stall request
fetch_err  output  1  one-cycle pulse when an error response is delivered
ARID  output  ID_WIDTH  read id, fixed to AR_ID
ARADDR  output  32  read address
ARLEN  output  4  fixed 0 (single beat)
ARSIZE  output  3  fixed 3'b010 (4 bytes)
ARBURST  output  2  fixed 2'b01 (INCR)
ARVALID  output  1  address valid
ARREADY  input  1  address ready
RID  input  ID_WIDTH  response id; not checked
RDATA  input  32  read data
RRESP  input  2  read response
RLAST  input  1  last beat
RVALID  input  1  data valid
RREADY  output  1  data ready

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk. On reset: state IDLE, ARVALID=0, RREADY=0, ARADDR=0, cpu_instr=0, fetch_err=0, data register=0, addr_q=0.
- A reset asserted mid-transaction drops ARVALID/RREADY immediately. Any outstanding response is the interconnect's responsibility.
- IDLE:
  - cpu_read=0: if_stall=0, cpu_instr=0, stay in IDLE.
  - cpu_read=1: if_stall=1, latch addr_q<=cpu_addr, go to AR.
- AR:
  - ARVALID=1, ARADDR=addr_q. ARVALID and ARADDR stay stable until ARREADY; they are never withdrawn, even on redirect. if_stall=1.
  - On ARVALID&&ARREADY go to R.
- R:
  - RREADY=1, if_stall=1.
  - On RVALID&&RREADY&&RLAST: capture RDATA into the data register, or NOP_INSTR if RRESP!=2'b00. Record the error flag and go to DONE.
  - RVALID without RLAST is a protocol error; ignore that beat and keep waiting.
- DONE:
  - cpu_instr = data register.
  - if_stall = 0 only if cpu_read=1 and cpu_addr==addr_q; otherwise if_stall=1 (stale response, discarded).
  - fetch_err pulses for the first DONE cycle with a matching address when the error flag is set.
  - Matching address, cpu_hold=1: stay in DONE, data stable, if_stall=0.
  - Matching address, cpu_hold=0: instruction consumed; go to IDLE.
  - Mismatch (redirect during the transaction) or cpu_read=0: go to IDLE without delivering.
- Minimum fetch latency: request seen in IDLE at cycle 0, AR at cycle 1 (ARREADY same cycle), R at cycle 2 (RVALID same cycle), instruction delivered with if_stall=0 at cycle 3. One fetch is outstanding at a time; no pipelining.
- The fixed AR fields (ARID, ARLEN, ARSIZE, ARBURST) are constant in all states.

Test Plan:
- Basic fetch: reset, then cpu_read=1, cpu_addr=0x100; ARREADY=1, RVALID=1, RDATA=0x00500093, RLAST=1 -> ARADDR=0x100 at cycle 1; if_stall=0 and cpu_instr=0x00500093 at cycle 3.
- AR backpressure: ARREADY low for 5 cycles, addr 0x200 -> ARVALID stays high and ARADDR=0x200 stable all 5 cycles; if_stall=1 throughout; exactly one handshake occurs.
- Redirect: during R, cpu_addr changes 0x104->0x400 -> the 0x104 data is never delivered with if_stall=0; a new AR with ARADDR=0x400 follows and delivers its data.
- Hold: delivery of 0x108 with cpu_hold=1 for 3 cycles -> if_stall=0, cpu_instr stable for 3 cycles, no new AR until hold drops.
- Error: RRESP=2'b10 on 0x10C -> cpu_instr=0x00000013, fetch_err high for exactly one cycle.
- WFI and reset: cpu_read=0 -> no ARVALID, if_stall=0, cpu_instr=0. Then rst during AR -> ARVALID=0 on the next cycle and state IDLE.
